// File: rtl/tff_mon_pkg.sv
// Shared types and widths for the T-flip-flop counter monitor.
// Imported by the predictor and the monitor top.
package tff_mon_pkg;

    localparam int STATE_W = 4;
    localparam int RUN_W   = 4;
    localparam int CNT_W   = 8;

    localparam logic [CNT_W-1:0] ERR_MAX = 8'd255;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 4'b0001,
        ACQ   = 4'b0010,
        LOCK  = 4'b0100,
        FAULT = 4'b1000
    } state_t;

endpackage

// File: rtl/tff_pred.sv
// Combinational next-state predictor for a 4-bit T-flip-flop up/down counter.
// Each bit toggles when all lower bits are 1 (up) or all lower bits are 0 (down).
module tff_pred
    import tff_mon_pkg::*;
(
    input  logic [3:0] prev,
    input  logic       dir,
    output logic [3:0] pred
);

    logic [3:0] src;
    logic [3:0] tog;

    // Down-counting is the up-count toggle chain run on complemented bits.
    assign src = dir ? prev : ~prev;

    assign tog[0] = 1'b1;
    assign tog[1] = src[0];
    assign tog[2] = src[1] & src[0];
    assign tog[3] = src[2] & src[1] & src[0];

    assign pred = prev ^ tog;

endmodule

// File: rtl/tff_count_monitor.sv
// Watches a 4-bit T-flip-flop counter, acquires lock on a run of correct
// transitions and reports mismatches, escalating to a sticky fault.
module tff_count_monitor
    import tff_mon_pkg::*;
#(
    parameter int unsigned LOCK_LEN  = 4,
    parameter int unsigned FAULT_LIM = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic [3:0]       q,
    input  logic             clr,
    output logic             locked,
    output logic             err,
    output logic             fault,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [RUN_W-1:0] LOCK_LEN_R  = RUN_W'(LOCK_LEN);
    localparam logic [RUN_W-1:0] FAULT_LIM_R = RUN_W'(FAULT_LIM);

    state_t             state, state_nx;
    logic [3:0]         prev, prev_nx;
    logic [RUN_W-1:0]   match_run, match_nx;
    logic [RUN_W-1:0]   miss_run, miss_nx;
    logic [CNT_W-1:0]   cnt_nx;
    logic               err_nx;
    logic [3:0]         pred;
    logic               hit;
    logic [RUN_W-1:0]   match_inc;
    logic [RUN_W-1:0]   miss_inc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == ERR_MAX) ? ERR_MAX : v + CNT_W'(1);
    endfunction

    tff_pred u_pred (
        .prev (prev),
        .dir  (dir),
        .pred (pred)
    );

    assign hit       = (q == pred);
    assign match_inc = match_run + RUN_W'(1);
    assign miss_inc  = miss_run + RUN_W'(1);

    always_comb begin
        state_nx = state;
        prev_nx  = prev;
        match_nx = match_run;
        miss_nx  = miss_run;
        cnt_nx   = err_cnt;
        err_nx   = 1'b0;
        if (clr) begin
            state_nx = IDLE;
            match_nx = '0;
            miss_nx  = '0;
            cnt_nx   = '0;
        end else if (en) begin
            case (state)
                IDLE: begin
                    prev_nx  = q;
                    match_nx = '0;
                    state_nx = ACQ;
                end
                ACQ: begin
                    prev_nx = q;
                    if (hit) begin
                        if (match_inc == LOCK_LEN_R) begin
                            state_nx = LOCK;
                            match_nx = '0;
                        end else begin
                            match_nx = match_inc;
                        end
                    end else begin
                        match_nx = '0;
                    end
                end
                LOCK: begin
                    // Resynchronise on the observed value even after a miss.
                    prev_nx = q;
                    if (hit) begin
                        miss_nx = '0;
                    end else begin
                        err_nx  = 1'b1;
                        cnt_nx  = sat_inc(err_cnt);
                        miss_nx = miss_inc;
                        if (miss_inc == FAULT_LIM_R) begin
                            state_nx = FAULT;
                        end
                    end
                end
                FAULT: begin
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            prev      <= '0;
            match_run <= '0;
            miss_run  <= '0;
            err_cnt   <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_nx;
            prev      <= prev_nx;
            match_run <= match_nx;
            miss_run  <= miss_nx;
            err_cnt   <= cnt_nx;
            err       <= err_nx;
        end
    end

    assign locked = (state == LOCK);
    assign fault  = (state == FAULT);

endmodule

// File: tb/tb_tff_count_monitor.sv
// Directed scoreboard bench for tff_count_monitor; an arithmetic mod-16
// reference model pushes expected outputs that are popped after each edge.
module tb_tff_count_monitor;

    localparam int LOCK_LEN  = 4;
    localparam int FAULT_LIM = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b0;
    logic       dir = 1'b1;
    logic [3:0] q   = 4'h0;
    logic       clr = 1'b0;
    logic       locked;
    logic       err;
    logic       fault;
    logic [7:0] err_cnt;

    typedef struct packed {
        logic       locked;
        logic       err;
        logic       fault;
        logic [7:0] err_cnt;
    } exp_t;

    exp_t sb[$];

    int n_chk = 0;
    int n_err = 0;

    int         m_state = 0;
    logic [3:0] m_prev  = 4'h0;
    int         m_match = 0;
    int         m_miss  = 0;
    int         m_cnt   = 0;

    tff_count_monitor #(
        .LOCK_LEN  (LOCK_LEN),
        .FAULT_LIM (FAULT_LIM)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .dir     (dir),
        .q       (q),
        .clr     (clr),
        .locked  (locked),
        .err     (err),
        .fault   (fault),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] model_pred(input logic [3:0] p, input logic d);
        int v;
        v = d ? (int'(p) + 1) % 16 : (int'(p) + 15) % 16;
        return 4'(v);
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_prev  = 4'h0;
        m_match = 0;
        m_miss  = 0;
        m_cnt   = 0;
    endtask

    task automatic step(input logic e, input logic d, input logic [3:0] qq, input logic c, input string tag);
        exp_t x;
        exp_t got;
        logic m_err;
        m_err = 1'b0;
        if (c) begin
            m_state = 0;
            m_match = 0;
            m_miss  = 0;
            m_cnt   = 0;
        end else if (e) begin
            case (m_state)
                0: begin
                    m_prev  = qq;
                    m_match = 0;
                    m_state = 1;
                end
                1: begin
                    if (qq == model_pred(m_prev, d)) begin
                        m_match++;
                        if (m_match == LOCK_LEN) begin
                            m_state = 2;
                            m_match = 0;
                        end
                    end else begin
                        m_match = 0;
                    end
                    m_prev = qq;
                end
                2: begin
                    if (qq == model_pred(m_prev, d)) begin
                        m_miss = 0;
                    end else begin
                        m_err = 1'b1;
                        if (m_cnt < 255) m_cnt++;
                        m_miss++;
                        if (m_miss == FAULT_LIM) m_state = 3;
                    end
                    m_prev = qq;
                end
                default: begin
                end
            endcase
        end
        x.locked  = (m_state == 2);
        x.err     = m_err;
        x.fault   = (m_state == 3);
        x.err_cnt = 8'(m_cnt);
        sb.push_back(x);

        @(negedge clk);
        en  = e;
        dir = d;
        q   = qq;
        clr = c;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 8'd1, 8'd0);
        end else begin
            got = sb.pop_front();
            chk({tag, "_locked"}, {7'd0, locked}, {7'd0, got.locked});
            chk({tag, "_err"},    {7'd0, err},    {7'd0, got.err});
            chk({tag, "_fault"},  {7'd0, fault},  {7'd0, got.fault});
            chk({tag, "_cnt"},    err_cnt,        got.err_cnt);
        end
    endtask

    initial begin
        logic [3:0] nq;
        logic       d;

        // Reset state
        #1;
        chk("rst_locked", {7'd0, locked}, 8'd0);
        chk("rst_err",    {7'd0, err},    8'd0);
        chk("rst_fault",  {7'd0, fault},  8'd0);
        chk("rst_cnt",    err_cnt,        8'd0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();

        // Acquire lock on 0..4 counting up
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 4'(i), 1'b0, "acq");
        chk("lock_after5", {7'd0, locked}, 8'd1);

        // Idle cycles hold state
        step(1'b0, 1'b1, 4'h9, 1'b0, "hold");
        step(1'b0, 1'b0, 4'h3, 1'b0, "hold");

        // Up wrap F -> 0
        for (int i = 5; i < 16; i++) step(1'b1, 1'b1, 4'(i), 1'b0, "upwrap");
        step(1'b1, 1'b1, 4'h0, 1'b0, "upwrap0");
        // Down wrap 0 -> F
        step(1'b1, 1'b0, 4'hF, 1'b0, "dnwrapF");
        step(1'b1, 1'b0, 4'hE, 1'b0, "dn");
        // Back up to 5 with dir change
        step(1'b1, 1'b1, 4'hF, 1'b0, "dirchg");
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 4'(i), 1'b0, "to5");

        // Three consecutive misses force fault
        step(1'b1, 1'b1, 4'h7, 1'b0, "miss7");
        step(1'b1, 1'b1, 4'h9, 1'b0, "miss9");
        step(1'b1, 1'b1, 4'hB, 1'b0, "missB");
        chk("fault_set", {7'd0, fault}, 8'd1);
        step(1'b1, 1'b1, 4'hC, 1'b0, "fault_ign");
        step(1'b1, 1'b1, 4'h2, 1'b0, "fault_ign");

        // Clear with a concurrent sample that must be discarded, then relock
        step(1'b1, 1'b1, 4'h0, 1'b1, "clr");
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 4'(i), 1'b0, "relock");

        // Single miss then recovery keeps lock
        step(1'b1, 1'b1, 4'h8, 1'b0, "onemiss");
        step(1'b1, 1'b1, 4'h9, 1'b0, "recover");
        step(1'b1, 1'b1, 4'hA, 1'b0, "recover");

        // Drive err_cnt into saturation: two misses then one hit, repeated
        for (int k = 0; k < 150; k++) begin
            for (int j = 0; j < 2; j++) begin
                d  = 1'($urandom_range(0, 1));
                nq = m_prev + 4'd2;
                step(1'b1, d, nq, 1'b0, "satmiss");
            end
            d  = 1'($urandom_range(0, 1));
            nq = model_pred(m_prev, d);
            step(1'b1, d, nq, 1'b0, "sathit");
        end
        chk("sat_255", err_cnt, 8'd255);
        chk("sat_locked", {7'd0, locked}, 8'd1);
        nq = m_prev + 4'd5;
        step(1'b1, 1'b1, nq, 1'b0, "sat_pulse");

        // Asynchronous reset between edges while locked
        #2;
        rst = 1'b0;
        en  = 1'b0;
        #1;
        model_reset();
        chk("arst_locked", {7'd0, locked}, 8'd0);
        chk("arst_err",    {7'd0, err},    8'd0);
        chk("arst_fault",  {7'd0, fault},  8'd0);
        chk("arst_cnt",    err_cnt,        8'd0);
        @(negedge clk);
        rst = 1'b1;

        // First sample after release is the capture
        for (int i = 7; i < 12; i++) step(1'b1, 1'b1, 4'(i), 1'b0, "post_rst");
        chk("post_rst_lock", {7'd0, locked}, 8'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
